// File: rtl/ping_pong_pkg.sv
// ============================================================================
// Module  : ping_pong_pkg
// Brief   : Shared types, default constants and width helper for the
//           ping/pong initiator slice.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ping_pong_pkg;

  // Default run configuration
  localparam int DEF_ROUNDS         = 10;
  localparam int DEF_START_DELAY    = 100;
  localparam int DEF_RESP_DELAY     = 1;
  localparam int DEF_TIMEOUT_CYCLES = 256;

  // Initiator sequencing states
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_WAIT = 3'd1,
    WAIT_PONG  = 3'd2,
    PONG_DLY   = 3'd3,
    DONE       = 3'd4,
    ERROR      = 3'd5
  } state_e;

  // Bits needed to hold the values 0..n (never less than one bit)
  function automatic int cnt_w(input int n);
    if (n <= 1) return 1;
    return $clog2(n + 1);
  endfunction

endpackage : ping_pong_pkg

`default_nettype wire

// File: rtl/ping_initiator_delay_timer.sv
// ============================================================================
// Module  : delay_timer
// Brief   : Loadable down-counter. A load takes priority over counting; the
//           counter holds at zero and flags it on 'zero'.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] r_cnt;

  // Count register: load wins, otherwise decrement while enabled and non-zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule : delay_timer

`default_nettype wire

// File: rtl/ping_initiator.sv
// ============================================================================
// Module  : ping_initiator
// Brief   : Drives the ping side of a ping/pong exchange: start delay, ping,
//           wait for pong, response delay, log round, repeat ROUNDS times.
//           Optional pong watchdog enabled by defining PING_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ping_initiator
  import ping_pong_pkg::*;
#(
  parameter int ROUNDS         = DEF_ROUNDS,
  parameter int START_DELAY    = DEF_START_DELAY,
  parameter int RESP_DELAY     = DEF_RESP_DELAY,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       ping_o,
  input  logic                       pong_i,
  output logic                       pong_log,
  output logic [cnt_w(ROUNDS)-1:0]   round_cnt,
  output logic                       busy,
  output logic                       done,
  output logic                       spurious,
  output logic                       err
);

  localparam int c_cnt_w   = cnt_w(ROUNDS);
  localparam int c_tmr_max = (START_DELAY > RESP_DELAY) ? START_DELAY : RESP_DELAY;
  localparam int c_tmr_w   = cnt_w(c_tmr_max);

  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(ROUNDS - 1);
  localparam logic [c_tmr_w-1:0] c_start_ld = c_tmr_w'(START_DELAY - 1);
  localparam logic [c_tmr_w-1:0] c_resp_ld  = c_tmr_w'(RESP_DELAY - 1);

  state_e               r_state;
  state_e               w_state_nxt;

  logic                 w_start_acc;
  logic                 w_pong_acc;
  logic                 w_tmr_load;
  logic [c_tmr_w-1:0]   w_tmr_load_val;
  logic                 w_tmr_en;
  logic                 w_tmr_zero;
  logic                 w_wd_zero;

  logic                 r_ping, r_log, r_busy, r_done, r_spur, r_err;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 w_ping_nxt, w_log_nxt, w_busy_nxt, w_done_nxt, w_spur_nxt, w_err_nxt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;

  // A start is only honoured while not running; a pong only counts when it
  // arrives in WAIT_PONG after the ping cycle itself.
  assign w_start_acc = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));
  assign w_pong_acc  = pong_i && (r_state == WAIT_PONG) && !r_ping;

  // Shared timer for the start delay and the response delay
  delay_timer #(
    .W (c_tmr_w)
  ) u_dly (
    .clk      (clk),
    .rst      (rst),
    .load     (w_tmr_load),
    .load_val (w_tmr_load_val),
    .en       (w_tmr_en),
    .zero     (w_tmr_zero)
  );

`ifdef PING_TIMEOUT_EN
  localparam int c_wd_w = cnt_w(TIMEOUT_CYCLES);
  localparam logic [c_wd_w-1:0] c_wd_ld = c_wd_w'(TIMEOUT_CYCLES - 1);

  // Watchdog re-armed on every WAIT_PONG entry, which always coincides with a ping
  delay_timer #(
    .W (c_wd_w)
  ) u_wd (
    .clk      (clk),
    .rst      (rst),
    .load     (w_ping_nxt),
    .load_val (c_wd_ld),
    .en       (r_state == WAIT_PONG),
    .zero     (w_wd_zero)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_wd_zero        = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ping  <= 1'b0;
      r_log   <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_spur  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ping  <= w_ping_nxt;
      r_log   <= w_log_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_spur  <= w_spur_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next state and delay timer control
  always_comb begin
    w_state_nxt    = r_state;
    w_tmr_load     = 1'b0;
    w_tmr_load_val = c_start_ld;
    w_tmr_en       = 1'b0;
    case (r_state)
      IDLE, DONE, ERROR: begin
        if (start) begin
          w_state_nxt = START_WAIT;
          w_tmr_load  = 1'b1;
        end
      end
      START_WAIT: begin
        w_tmr_en = 1'b1;
        if (w_tmr_zero) w_state_nxt = WAIT_PONG;
      end
      WAIT_PONG: begin
        // A pong in the expiry cycle still wins over the watchdog
        if (w_pong_acc) begin
          w_state_nxt    = PONG_DLY;
          w_tmr_load     = 1'b1;
          w_tmr_load_val = c_resp_ld;
        end else if (w_wd_zero) begin
          w_state_nxt = ERROR;
        end
      end
      PONG_DLY: begin
        w_tmr_en = 1'b1;
        if (w_tmr_zero) w_state_nxt = (r_cnt == c_last_cnt) ? DONE : WAIT_PONG;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    w_ping_nxt = (w_state_nxt == WAIT_PONG) && (r_state != WAIT_PONG);
    w_log_nxt  = (r_state == PONG_DLY) && w_tmr_zero;
    w_busy_nxt = (w_state_nxt == START_WAIT) || (w_state_nxt == WAIT_PONG) ||
                 (w_state_nxt == PONG_DLY);
    w_done_nxt = (w_state_nxt == DONE);
    w_err_nxt  = (w_state_nxt == ERROR);
    w_cnt_nxt  = r_cnt;
    w_spur_nxt = r_spur | (pong_i & ~w_pong_acc);
    if (w_start_acc) begin
      w_cnt_nxt  = '0;
      w_spur_nxt = 1'b0;
    end else if (w_log_nxt) begin
      w_cnt_nxt  = r_cnt + c_cnt_w'(1);
    end
  end

  assign ping_o    = r_ping;
  assign pong_log  = r_log;
  assign round_cnt = r_cnt;
  assign busy      = r_busy;
  assign done      = r_done;
  assign spurious  = r_spur;
  assign err       = r_err;

endmodule : ping_initiator

`default_nettype wire
